// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game: state codes and
// the default sequence stored in the ROM.
package jogo_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'd0,
        PREPARA        = 5'd1,
        MOSTRA_LIGA    = 5'd2,
        MOSTRA_DESLIGA = 5'd3,
        ESPERA_JOGADA  = 5'd4,
        REGISTRA       = 5'd5,
        COMPARA        = 5'd6,
        PROXIMA_RODADA = 5'd7,
        FIM_ACERTO     = 5'd8,
        FIM_ERRO       = 5'd9,
        FIM_TIMEOUT    = 5'd10
    } estado_t;

    localparam int SEQ_PADRAO_LEN = 16;

    // Deeper ROMs repeat the 16-entry pattern.
    function automatic logic [3:0] seq_padrao(input int unsigned idx);
        logic [3:0] v;
        case (idx[3:0])
            4'd0:    v = 4'b0001;
            4'd1:    v = 4'b0010;
            4'd2:    v = 4'b0100;
            4'd3:    v = 4'b1000;
            4'd4:    v = 4'b0100;
            4'd5:    v = 4'b0010;
            4'd6:    v = 4'b0001;
            4'd7:    v = 4'b0001;
            4'd8:    v = 4'b0010;
            4'd9:    v = 4'b0010;
            4'd10:   v = 4'b0100;
            4'd11:   v = 4'b0100;
            4'd12:   v = 4'b1000;
            4'd13:   v = 4'b1000;
            4'd14:   v = 4'b0001;
            4'd15:   v = 4'b0100;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rom_sequencia.sv
// Combinational-read sequence ROM, NUM_CHAVES wide and PROFUNDIDADE deep,
// filled from the package's default sequence.
module rom_sequencia
    import jogo_pkg::*;
#(
    parameter int NUM_CHAVES   = 4,
    parameter int PROFUNDIDADE = 16
) (
    input  logic [$clog2(PROFUNDIDADE)-1:0] endereco,
    output logic [NUM_CHAVES-1:0]           dado
);

    logic [NUM_CHAVES-1:0] conteudo [PROFUNDIDADE];

    for (genvar i = 0; i < PROFUNDIDADE; i++) begin : g_rom
        assign conteudo[i] = NUM_CHAVES'(seq_padrao(i));
    end

    assign dado = conteudo[endereco];

endmodule

// File: rtl/jogo_memoria_param.sv
// Sequence-memory game: controller FSM, round/element counters,
// play and replay timers around the sequence ROM.
module jogo_memoria_param
    import jogo_pkg::*;
#(
    parameter int NUM_CHAVES     = 4,
    parameter int PROFUNDIDADE   = 16,
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int MOSTRA_CICLOS  = 500
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic [NUM_CHAVES-1:0]           chaves,
    input  logic                            modo_mostra,
    output logic                            acertou,
    output logic                            errou,
    output logic                            pronto,
    output logic                            timeout,
    output logic [NUM_CHAVES-1:0]           leds,
    output logic [4:0]                      db_estado,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_contagem,
    output logic [NUM_CHAVES-1:0]           db_jogada
);

    localparam int AW = $clog2(PROFUNDIDADE);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int MW = $clog2(MOSTRA_CICLOS + 1);

    localparam logic [AW-1:0] ULTIMA     = AW'(PROFUNDIDADE - 1);
    localparam logic [TW-1:0] TMR_FIM    = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [MW-1:0] MOSTRA_FIM = MW'(MOSTRA_CICLOS - 1);

    estado_t estado;
    estado_t estado_prox;

    logic iniciar_d;
    logic chave_d;
    logic borda_iniciar;
    logic borda_jogada;
    logic modo_q;

    logic [AW-1:0]         rodada;
    logic [AW-1:0]         contagem;
    logic [NUM_CHAVES-1:0] jogada;
    logic [NUM_CHAVES-1:0] elemento;
    logic [TW-1:0]         tmr_jogada;
    logic [MW-1:0]         tmr_mostra;

    logic fim_jogada;
    logic fim_mostra;
    logic igual;
    logic ultimo_elem;

    logic limpa;
    logic inc_cont;
    logic clr_cont;
    logic inc_rod;
    logic grava;

    rom_sequencia #(
        .NUM_CHAVES  (NUM_CHAVES),
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_rom (
        .endereco(contagem),
        .dado    (elemento)
    );

    assign borda_iniciar = iniciar & ~iniciar_d;
    assign borda_jogada  = (|chaves) & ~chave_d;
    assign fim_jogada    = (tmr_jogada == TMR_FIM);
    assign fim_mostra    = (tmr_mostra == MOSTRA_FIM);
    assign igual         = (jogada == elemento);
    assign ultimo_elem   = (contagem == rodada);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iniciar_d <= 1'b0;
            chave_d   <= 1'b0;
        end else begin
            iniciar_d <= iniciar;
            chave_d   <= |chaves;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        limpa       = 1'b0;
        inc_cont    = 1'b0;
        clr_cont    = 1'b0;
        inc_rod     = 1'b0;
        grava       = 1'b0;
        unique case (estado)
            INICIAL: begin
                if (borda_iniciar) estado_prox = PREPARA;
            end
            PREPARA: begin
                limpa       = 1'b1;
                estado_prox = modo_mostra ? MOSTRA_LIGA : ESPERA_JOGADA;
            end
            MOSTRA_LIGA: begin
                if (fim_mostra) estado_prox = MOSTRA_DESLIGA;
            end
            MOSTRA_DESLIGA: begin
                if (fim_mostra) begin
                    if (ultimo_elem) begin
                        clr_cont    = 1'b1;
                        estado_prox = ESPERA_JOGADA;
                    end else begin
                        inc_cont    = 1'b1;
                        estado_prox = MOSTRA_LIGA;
                    end
                end
            end
            ESPERA_JOGADA: begin
                // A play arriving on the last timer cycle still counts.
                if (borda_jogada)    estado_prox = REGISTRA;
                else if (fim_jogada) estado_prox = FIM_TIMEOUT;
            end
            REGISTRA: begin
                grava       = 1'b1;
                estado_prox = COMPARA;
            end
            COMPARA: begin
                if (!igual) begin
                    estado_prox = FIM_ERRO;
                end else if (!ultimo_elem) begin
                    inc_cont    = 1'b1;
                    estado_prox = ESPERA_JOGADA;
                end else if (rodada == ULTIMA) begin
                    estado_prox = FIM_ACERTO;
                end else begin
                    estado_prox = PROXIMA_RODADA;
                end
            end
            PROXIMA_RODADA: begin
                inc_rod     = 1'b1;
                clr_cont    = 1'b1;
                estado_prox = modo_q ? MOSTRA_LIGA : ESPERA_JOGADA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (borda_iniciar) estado_prox = PREPARA;
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rodada   <= '0;
            contagem <= '0;
            jogada   <= '0;
            modo_q   <= 1'b0;
        end else if (limpa) begin
            rodada   <= '0;
            contagem <= '0;
            jogada   <= '0;
            modo_q   <= modo_mostra;
        end else begin
            if (inc_rod) rodada <= rodada + AW'(1);
            if (clr_cont)      contagem <= '0;
            else if (inc_cont) contagem <= contagem + AW'(1);
            if (grava) jogada <= chaves;
        end
    end

    // Timers restart whenever their state is entered or left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_jogada <= '0;
            tmr_mostra <= '0;
        end else begin
            if (estado == ESPERA_JOGADA && estado_prox == ESPERA_JOGADA)
                tmr_jogada <= tmr_jogada + TW'(1);
            else
                tmr_jogada <= '0;
            if ((estado == MOSTRA_LIGA || estado == MOSTRA_DESLIGA) &&
                estado_prox == estado)
                tmr_mostra <= tmr_mostra + MW'(1);
            else
                tmr_mostra <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acertou <= 1'b0;
            errou   <= 1'b0;
            pronto  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            acertou <= (estado_prox == FIM_ACERTO);
            errou   <= (estado_prox == FIM_ERRO) ||
                       (estado_prox == FIM_TIMEOUT);
            timeout <= (estado_prox == FIM_TIMEOUT);
            pronto  <= (estado_prox == FIM_ACERTO) ||
                       (estado_prox == FIM_ERRO) ||
                       (estado_prox == FIM_TIMEOUT);
        end
    end

    always_comb begin
        leds = chaves;
        if (estado == MOSTRA_LIGA)         leds = elemento;
        else if (estado == MOSTRA_DESLIGA) leds = '0;
    end

    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_contagem = contagem;
    assign db_jogada   = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Scoreboard bench for jogo_memoria_param with short timeout and replay.
module tb_jogo_memoria_param;

    localparam int NC   = 4;
    localparam int PROF = 16;
    localparam int TO   = 50;
    localparam int MC   = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic [NC-1:0] chaves = '0;
    logic          modo_mostra = 1'b0;
    logic          acertou;
    logic          errou;
    logic          pronto;
    logic          timeout;
    logic [NC-1:0] leds;
    logic [4:0]    db_estado;
    logic [3:0]    db_rodada;
    logic [3:0]    db_contagem;
    logic [NC-1:0] db_jogada;

    always #5 clock = ~clock;

    jogo_memoria_param #(
        .NUM_CHAVES    (NC),
        .PROFUNDIDADE  (PROF),
        .TIMEOUT_CICLOS(TO),
        .MOSTRA_CICLOS (MC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .chaves     (chaves),
        .modo_mostra(modo_mostra),
        .acertou    (acertou),
        .errou      (errou),
        .pronto     (pronto),
        .timeout    (timeout),
        .leds       (leds),
        .db_estado  (db_estado),
        .db_rodada  (db_rodada),
        .db_contagem(db_contagem),
        .db_jogada  (db_jogada)
    );

    typedef struct packed {
        logic       acertou;
        logic       errou;
        logic       pronto;
        logic       timeout;
        logic [4:0] estado;
        logic [3:0] rodada;
        logic [3:0] contagem;
        logic [3:0] jogada;
    } obs_t;

    logic [3:0] seq_ref [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    obs_t       fila[$];
    logic [3:0] fila_leds[$];
    int         testes = 0;
    int         falhas = 0;

    function automatic obs_t observa();
        return {acertou, errou, pronto, timeout,
                db_estado, db_rodada, db_contagem, db_jogada};
    endfunction

    // Expected outputs three cycles after a correct play of element c in round r.
    function automatic obs_t modelo_acerto(input int r, input int c);
        obs_t e;
        e = '0;
        e.rodada = 4'(r);
        e.jogada = seq_ref[c];
        if (c < r) begin
            e.estado   = 5'd4;
            e.contagem = 4'(c + 1);
        end else if (r == PROF - 1) begin
            e.estado   = 5'd8;
            e.contagem = 4'(c);
            e.acertou  = 1'b1;
            e.pronto   = 1'b1;
        end else begin
            e.estado   = 5'd7;
            e.contagem = 4'(c);
        end
        return e;
    endfunction

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        ciclos(1);
        iniciar = 1'b0;
    endtask

    task automatic pulso_reset();
        reset = 1'b1;
        ciclos(2);
        reset = 1'b0;
        ciclos(1);
    endtask

    task automatic espera_estado(input logic [4:0] e, input int limite,
                                 output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            if (db_estado === e) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        obs_t       esp;
        logic [3:0] lesp;
        reset = 1'b1;
        chaves = '0;
        ciclos(2);
        fila.push_back('0);
        fila_leds.push_back(4'b0000);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL reset_outputs: got %h expected %h", observa(), esp);
        end
        lesp = fila_leds.pop_front();
        testes++;
        if (leds !== lesp) begin
            falhas++;
            $display("FAIL reset_leds: got %b expected %b", leds, lesp);
        end
        reset = 1'b0;
        ciclos(3);
        testes++;
        if (db_estado !== 5'd0) begin
            falhas++;
            $display("FAIL reset_idle: got %0d expected 0", db_estado);
        end
    endtask

    task automatic test_vitoria();
        obs_t esp;
        obs_t obs;
        bit   ok;
        modo_mostra = 1'b0;
        pulso_iniciar();
        espera_estado(5'd4, 10, ok);
        testes++;
        if (!ok) begin
            falhas++;
            $display("FAIL vitoria_inicio: got %0d expected 4", db_estado);
        end
        for (int r = 0; r < PROF; r++) begin
            for (int c = 0; c <= r; c++) begin
                fila.push_back(modelo_acerto(r, c));
                chaves = seq_ref[c];
                ciclos(3);
                esp = fila.pop_front();
                obs = observa();
                testes++;
                if (obs !== esp) begin
                    falhas++;
                    $display("FAIL vitoria r%0d c%0d: got %h expected %h",
                             r, c, obs, esp);
                end
                ciclos(7);
                chaves = '0;
                ciclos(10);
            end
        end
        fila.push_back(modelo_acerto(PROF - 1, PROF - 1));
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL vitoria_mantida: got %h expected %h", observa(), esp);
        end
    endtask

    task automatic test_erro();
        obs_t esp;
        obs_t obs;
        bit   ok;
        bit   errado;
        pulso_iniciar();
        fila.push_back({4'b0000, 5'd1, 4'd15, 4'd15, 4'b0100});
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL erro_prepara: got %h expected %h", observa(), esp);
        end
        espera_estado(5'd4, 10, ok);
        fila.push_back({4'b0000, 5'd4, 4'd0, 4'd0, 4'b0000});
        esp = fila.pop_front();
        testes++;
        if (!ok || observa() !== esp) begin
            falhas++;
            $display("FAIL erro_limpo: got %h expected %h", observa(), esp);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c <= r; c++) begin
                errado = (r == 3 && c == 2);
                if (errado) begin
                    fila.push_back({4'b0110, 5'd9, 4'd3, 4'd2, 4'b1000});
                    chaves = 4'b1000;
                end else begin
                    fila.push_back(modelo_acerto(r, c));
                    chaves = seq_ref[c];
                end
                ciclos(3);
                esp = fila.pop_front();
                obs = observa();
                testes++;
                if (obs !== esp) begin
                    falhas++;
                    $display("FAIL erro r%0d c%0d: got %h expected %h",
                             r, c, obs, esp);
                end
                ciclos(7);
                chaves = '0;
                ciclos(10);
                if (errado) break;
            end
        end
        fila.push_back({4'b0110, 5'd9, 4'd3, 4'd2, 4'b1000});
        chaves = 4'b0100;
        ciclos(3);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL erro_ignora_jogada: got %h expected %h",
                     observa(), esp);
        end
        ciclos(7);
        chaves = '0;
        ciclos(10);
    endtask

    task automatic test_timeout();
        obs_t esp;
        pulso_iniciar();
        fila.push_back({4'b0000, 5'd1, 4'd3, 4'd2, 4'b1000});
        ciclos(1);
        fila.push_back({4'b0000, 5'd4, 4'd0, 4'd0, 4'b0000});
        esp = fila.pop_front();
        testes++;
        if (db_estado !== 5'd4 || pronto !== 1'b0) begin
            falhas++;
            $display("FAIL timeout_espera: got %h expected %h", observa(),
                     fila[0]);
        end
        ciclos(49);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL timeout_limite: got %h expected %h", observa(), esp);
        end
        fila.push_back({4'b0111, 5'd10, 4'd0, 4'd0, 4'b0000});
        ciclos(1);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL timeout_fim: got %h expected %h", observa(), esp);
        end
        fila.push_back({4'b0000, 5'd1, 4'd0, 4'd0, 4'b0000});
        pulso_iniciar();
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL timeout_reinicio: got %h expected %h",
                     observa(), esp);
        end
    endtask

    task automatic test_mostra();
        obs_t       esp;
        logic [3:0] lesp;
        bit         ok;
        modo_mostra = 1'b1;
        pulso_reset();
        pulso_iniciar();
        for (int r = 0; r < 2; r++) begin
            espera_estado(5'd4, 100, ok);
            testes++;
            if (!ok) begin
                falhas++;
                $display("FAIL mostra_espera r%0d: got %0d expected 4",
                         r, db_estado);
            end
            for (int c = 0; c <= r; c++) begin
                fila.push_back(modelo_acerto(r, c));
                chaves = seq_ref[c];
                if (r == 1 && c == 1) begin
                    ciclos(2);
                    chaves = '0;
                    ciclos(1);
                end else begin
                    ciclos(3);
                end
                esp = fila.pop_front();
                testes++;
                if (observa() !== esp) begin
                    falhas++;
                    $display("FAIL mostra r%0d c%0d: got %h expected %h",
                             r, c, observa(), esp);
                end
                if (!(r == 1 && c == 1)) begin
                    ciclos(7);
                    chaves = '0;
                    ciclos(10);
                end
            end
        end
        for (int i = 0; i < 6 * 3; i++)
            fila_leds.push_back(((i % 6) < 3) ? seq_ref[i / 6] : 4'b0000);
        ciclos(1);
        for (int i = 0; i < 6 * 3; i++) begin
            lesp = fila_leds.pop_front();
            testes++;
            if (leds !== lesp) begin
                falhas++;
                $display("FAIL mostra_leds ciclo %0d: got %b expected %b",
                         i, leds, lesp);
            end
            ciclos(1);
        end
        testes++;
        if (db_estado !== 5'd4 || db_contagem !== 4'd0) begin
            falhas++;
            $display("FAIL mostra_fim: got estado %0d contagem %0d expected 4 0",
                     db_estado, db_contagem);
        end
        chaves = seq_ref[0];
        #1;
        testes++;
        if (leds !== seq_ref[0]) begin
            falhas++;
            $display("FAIL mostra_eco: got %b expected %b", leds, seq_ref[0]);
        end
        fila.push_back(modelo_acerto(2, 0));
        ciclos(3);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL mostra_r2c0: got %h expected %h", observa(), esp);
        end
        ciclos(7);
        chaves = '0;
        ciclos(10);
    endtask

    task automatic test_multibit();
        obs_t esp;
        bit   ok;
        modo_mostra = 1'b0;
        pulso_reset();
        pulso_iniciar();
        espera_estado(5'd4, 10, ok);
        fila.push_back({4'b0110, 5'd9, 4'd0, 4'd0, 4'b0011});
        chaves = 4'b0011;
        ciclos(3);
        esp = fila.pop_front();
        testes++;
        if (!ok || observa() !== esp) begin
            falhas++;
            $display("FAIL multibit: got %h expected %h", observa(), esp);
        end
        ciclos(7);
        chaves = '0;
        ciclos(10);
        pulso_iniciar();
        espera_estado(5'd4, 10, ok);
        fila.push_back(modelo_acerto(0, 0));
        chaves = seq_ref[0];
        ciclos(3);
        esp = fila.pop_front();
        testes++;
        if (!ok || observa() !== esp) begin
            falhas++;
            $display("FAIL segura_r0: got %h expected %h", observa(), esp);
        end
        ciclos(7);
        chaves = '0;
        ciclos(10);
        espera_estado(5'd4, 10, ok);
        fila.push_back(modelo_acerto(1, 0));
        fila.push_back(modelo_acerto(1, 0));
        fila.push_back(modelo_acerto(1, 0));
        fila.push_back({4'b0111, 5'd10, 4'd1, 4'd1, 4'b0001});
        chaves = 4'b0001;
        ciclos(3);
        esp = fila.pop_front();
        testes++;
        if (!ok || observa() !== esp) begin
            falhas++;
            $display("FAIL segura_r1: got %h expected %h", observa(), esp);
        end
        ciclos(37);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL segura_40: got %h expected %h", observa(), esp);
        end
        chaves = '0;
        ciclos(12);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL segura_pre_timeout: got %h expected %h",
                     observa(), esp);
        end
        ciclos(1);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp) begin
            falhas++;
            $display("FAIL segura_timeout: got %h expected %h", observa(), esp);
        end
    endtask

    task automatic test_reset_mostra();
        obs_t esp;
        bit   ok;
        modo_mostra = 1'b1;
        pulso_reset();
        pulso_iniciar();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c <= r; c++) begin
                espera_estado(5'd4, 200, ok);
                fila.push_back(modelo_acerto(r, c));
                chaves = seq_ref[c];
                ciclos(3);
                esp = fila.pop_front();
                testes++;
                if (!ok || observa() !== esp) begin
                    falhas++;
                    $display("FAIL rst_mostra r%0d c%0d: got %h expected %h",
                             r, c, observa(), esp);
                end
                ciclos(7);
                chaves = '0;
                if (!(r == 4 && c == 4)) ciclos(10);
            end
        end
        ciclos(2);
        fila.push_back({4'b0000, 5'd2, 4'd5, 4'd1, 4'b0100});
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp || leds !== seq_ref[1]) begin
            falhas++;
            $display("FAIL rst_mostra_replay: got %h leds %b expected %h leds %b",
                     observa(), leds, esp, seq_ref[1]);
        end
        #2;
        reset = 1'b1;
        #1;
        fila.push_back('0);
        esp = fila.pop_front();
        testes++;
        if (observa() !== esp || leds !== 4'b0000) begin
            falhas++;
            $display("FAIL rst_async: got %h leds %b expected %h leds 0000",
                     observa(), leds, esp);
        end
        ciclos(1);
        reset = 1'b0;
        ciclos(1);
        testes++;
        if (db_estado !== 5'd0 || observa() !== '0) begin
            falhas++;
            $display("FAIL rst_liberado: got %h expected 0", observa());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vitoria();
        test_erro();
        test_timeout();
        test_mostra();
        test_multibit();
        test_reset_mostra();
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
